// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller and the pipeline registers.
package hazard_ctrl_pkg;

  localparam int unsigned NREG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // One in-flight destination tracked alongside a pipeline register.
  typedef struct packed {
    logic              valid;
    logic [NREG_W-1:0] wreg;
    logic              is_load;
  } slot_t;

  function automatic slot_t slot_bubble();
    slot_t s;
    s.valid   = 1'b0;
    s.wreg    = '0;
    s.is_load = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_pick.sv
// Three-slot priority matcher for one ID source operand: nearest in-flight writer wins.
module hazard_ctrl_fwd_pick
  import hazard_ctrl_pkg::*;
(
  input  logic              have_inst_i,
  input  logic [NREG_W-1:0] rs_i,
  input  logic              used_i,
  input  slot_t             ex_i,
  input  slot_t             mem_i,
  input  slot_t             wb_i,
  output logic [1:0]        sel_o,
  output logic              ex_load_hit_o
);

  logic qual;
  logic hit_ex, hit_mem, hit_wb;
  logic unused_is_load;

  // r0 is hardwired to zero, so a write to it is never a real producer.
  assign qual    = used_i & have_inst_i & (rs_i != '0);
  assign hit_ex  = qual & ex_i.valid  & (ex_i.wreg  == rs_i);
  assign hit_mem = qual & mem_i.valid & (mem_i.wreg == rs_i);
  assign hit_wb  = qual & wb_i.valid  & (wb_i.wreg  == rs_i);

  assign unused_is_load = mem_i.is_load ^ wb_i.is_load;

  always_comb begin
    sel_o = FWD_RF;
    if (hit_ex) begin
      sel_o = FWD_EX;
    end else if (hit_mem) begin
      sel_o = FWD_MEM;
    end else if (hit_wb) begin
      sel_o = FWD_WB;
    end
  end

  assign ex_load_hit_o = hit_ex & ex_i.is_load;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: shadows EX/MEM/WB destinations and drives the
// forwarding selects, load-use stall, branch flush and saturating event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_have_inst,
  input  logic [NREG_W-1:0] id_rR1,
  input  logic              id_rR1_used,
  input  logic [NREG_W-1:0] id_rR2,
  input  logic              id_rR2_used,
  input  logic [NREG_W-1:0] id_wb_reg,
  input  logic              id_wb_ena,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  slot_t ex_s_q, mem_s_q, wb_s_q;
  slot_t ex_s_d;
  logic  [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic  [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic  lu1, lu2, lu, br, stall_ev;

  hazard_ctrl_fwd_pick u_pick1 (
    .have_inst_i   (id_have_inst),
    .rs_i          (id_rR1),
    .used_i        (id_rR1_used),
    .ex_i          (ex_s_q),
    .mem_i         (mem_s_q),
    .wb_i          (wb_s_q),
    .sel_o         (fwd_sel1),
    .ex_load_hit_o (lu1)
  );

  hazard_ctrl_fwd_pick u_pick2 (
    .have_inst_i   (id_have_inst),
    .rs_i          (id_rR2),
    .used_i        (id_rR2_used),
    .ex_i          (ex_s_q),
    .mem_i         (mem_s_q),
    .wb_i          (wb_s_q),
    .sel_o         (fwd_sel2),
    .ex_load_hit_o (lu2)
  );

  assign lu       = lu1 | lu2;
  assign br       = ex_branch_taken;
  // A taken branch overrides the stall: the PC has to load the target.
  assign stall_ev = lu & ~br;

  assign stall_pc   = stall_ev;
  assign stall_ifid = stall_ev;
  assign flush_ifid = br;
  assign flush_idex = br | lu;

  always_comb begin
    ex_s_d = slot_bubble();
    if (!flush_idex) begin
      ex_s_d.valid   = id_have_inst & id_wb_ena;
      ex_s_d.wreg    = id_wb_reg;
      ex_s_d.is_load = id_is_load;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (br && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_s_q      <= slot_bubble();
      mem_s_q     <= slot_bubble();
      wb_s_q      <= slot_bubble();
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_s_q      <= ex_s_d;
      mem_s_q     <= ex_s_q;
      wb_s_q      <= mem_s_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding priority, load-use, branch flush, reset, saturation.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned CntW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_have_inst;
  logic [NREG_W-1:0] id_rR1, id_rR2, id_wb_reg;
  logic              id_rR1_used, id_rR2_used, id_wb_ena, id_is_load;
  logic              ex_branch_taken;
  logic [1:0]        fwd_sel1, fwd_sel2;
  logic              stall_pc, stall_ifid, flush_ifid, flush_idex;
  logic [CntW-1:0]   stall_cnt, flush_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  hazard_ctrl #(
    .CNT_W (CntW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_have_inst    (id_have_inst),
    .id_rR1          (id_rR1),
    .id_rR1_used     (id_rR1_used),
    .id_rR2          (id_rR2),
    .id_rR2_used     (id_rR2_used),
    .id_wb_reg       (id_wb_reg),
    .id_wb_ena       (id_wb_ena),
    .id_is_load      (id_is_load),
    .ex_branch_taken (ex_branch_taken),
    .fwd_sel1        (fwd_sel1),
    .fwd_sel2        (fwd_sel2),
    .stall_pc        (stall_pc),
    .stall_ifid      (stall_ifid),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the ID stage and let the combinational outputs settle.
  task automatic id(input logic have, input logic [NREG_W-1:0] r1, input logic u1,
                    input logic [NREG_W-1:0] r2, input logic u2,
                    input logic [NREG_W-1:0] wb, input logic wena, input logic ld);
    id_have_inst = have;
    id_rR1       = r1;
    id_rR1_used  = u1;
    id_rR2       = r2;
    id_rR2_used  = u2;
    id_wb_reg    = wb;
    id_wb_ena    = wena;
    id_is_load   = ld;
    #1;
  endtask

  task automatic idle_clear();
    id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (3) step();
  endtask

  initial begin
    rst             = 1'b0;
    ex_branch_taken = 1'b0;
    id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    check("rst_fwd1", 32'(fwd_sel1), 32'd0);
    check("rst_stall", 32'(stall_pc), 32'd0);
    check("rst_flush", 32'(flush_idex), 32'd0);
    check("rst_scnt", 32'(stall_cnt), 32'd0);
    check("rst_fcnt", 32'(flush_cnt), 32'd0);
    step();
    rst = 1'b1;
    step();

    // Back-to-back ALU: add r5, then sub r5, r3.
    id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0);
    check("alu_pre_fwd1", 32'(fwd_sel1), 32'd0);
    step();
    id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0);
    check("alu_fwd1", 32'(fwd_sel1), 32'(FWD_EX));
    check("alu_fwd2", 32'(fwd_sel2), 32'(FWD_RF));
    check("alu_stall", 32'(stall_pc), 32'd0);
    check("alu_flush", 32'(flush_idex), 32'd0);
    step();
    idle_clear();

    // Load-use: ld r6, then add r2, r6.
    id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    step();
    id(1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0);
    check("lu_stall_pc", 32'(stall_pc), 32'd1);
    check("lu_stall_ifid", 32'(stall_ifid), 32'd1);
    check("lu_flush_idex", 32'(flush_idex), 32'd1);
    check("lu_flush_ifid", 32'(flush_ifid), 32'd0);
    check("lu_fwd2_ex", 32'(fwd_sel2), 32'(FWD_EX));
    check("lu_scnt0", 32'(stall_cnt), 32'd0);
    step();
    check("lu_fwd2_mem", 32'(fwd_sel2), 32'(FWD_MEM));
    check("lu_fwd1", 32'(fwd_sel1), 32'(FWD_RF));
    check("lu_stall2", 32'(stall_pc), 32'd0);
    check("lu_flush2", 32'(flush_idex), 32'd0);
    check("lu_scnt1", 32'(stall_cnt), 32'd1);
    idle_clear();

    // Priority: three writes to r7, then a reader.
    repeat (3) begin
      id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      step();
    end
    id(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
    check("pri_ex", 32'(fwd_sel1), 32'(FWD_EX));
    check("pri_unused2", 32'(fwd_sel2), 32'(FWD_RF));
    idle_clear();
    // Two writes, a bubble, then the reader ages through MEM and WB.
    repeat (2) begin
      id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      step();
    end
    id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("pri_mem", 32'(fwd_sel1), 32'(FWD_MEM));
    id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("pri_wb", 32'(fwd_sel1), 32'(FWD_WB));
    id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("pri_rf", 32'(fwd_sel1), 32'(FWD_RF));
    id(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("noinst_fwd", 32'(fwd_sel1), 32'(FWD_RF));
    idle_clear();

    // Taken branch while a writer of r10 sits in ID.
    id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    check("br_flush_ifid", 32'(flush_ifid), 32'd1);
    check("br_flush_idex", 32'(flush_idex), 32'd1);
    check("br_stall", 32'(stall_pc), 32'd0);
    check("br_fcnt0", 32'(flush_cnt), 32'd0);
    step();
    ex_branch_taken = 1'b0;
    id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("br_shadow_fwd", 32'(fwd_sel1), 32'(FWD_RF));
    check("br_fcnt1", 32'(flush_cnt), 32'd1);
    check("br_flush_off", 32'(flush_ifid), 32'd0);
    idle_clear();

    // Branch and load-use together: branch wins.
    id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
    step();
    id(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    check("both_stall_pc", 32'(stall_pc), 32'd0);
    check("both_stall_ifid", 32'(stall_ifid), 32'd0);
    check("both_flush_ifid", 32'(flush_ifid), 32'd1);
    check("both_flush_idex", 32'(flush_idex), 32'd1);
    step();
    ex_branch_taken = 1'b0;
    #1;
    check("both_scnt", 32'(stall_cnt), 32'd1);
    check("both_fcnt", 32'(flush_cnt), 32'd2);
    idle_clear();

    // A load to r0 followed by a reader of r0: no forward, no stall.
    id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    check("r0_fwd1", 32'(fwd_sel1), 32'(FWD_RF));
    check("r0_fwd2", 32'(fwd_sel2), 32'(FWD_RF));
    check("r0_stall", 32'(stall_pc), 32'd0);
    idle_clear();

    // Asynchronous reset in the middle of a load-use stall.
    id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
    step();
    id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("arst_pre_stall", 32'(stall_pc), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_stall", 32'(stall_pc), 32'd0);
    check("arst_fwd1", 32'(fwd_sel1), 32'(FWD_RF));
    check("arst_flush_idex", 32'(flush_idex), 32'd0);
    check("arst_scnt", 32'(stall_cnt), 32'd0);
    check("arst_fcnt", 32'(flush_cnt), 32'd0);
    ex_branch_taken = 1'b1;
    #1;
    check("arst_br_flush", 32'(flush_ifid), 32'd1);
    ex_branch_taken = 1'b0;
    step();
    rst = 1'b1;
    idle_clear();

    // Saturation: a load reading its own destination stalls every other cycle.
    id(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1);
    repeat (40) step();
    id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    check("sat_scnt", 32'(stall_cnt), 32'd15);
    check("sat_fcnt", 32'(flush_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
